// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output stage: FSM state encodings,
// complex sample packing and the bit-reversal helper.
package fft_pkg;

  // Output stage states: gather final-stage writes, then stream bins out.
  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } fft_state_t;

  // A complex sample is {re, im}, each DATA_WIDTH bits.
  localparam int CPLX_PARTS = 2;

  // Reverse the low 'width' bits of addr. Upper result bits are zero.
  // Built from shifts so that every select is a constant slice.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int width);
    logic [31:0] a;
    logic [31:0] r;
    a = addr;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r = {r[30:0], a[0]};
      a = a >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Bin stream from the FFT output stage: valid/ready with bin index and
// last-bin marker. The master side produces bins, the slave consumes them.
interface fft_out_reorder_if
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                             out_valid;
  logic                             out_ready;
  logic [CPLX_PARTS*DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0]            out_index;
  logic                             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fft_bitrev_addr.sv
// Combinational bit-reversal of a buffer address. Used by the output
// stage when the FFT core leaves its results in bit-reversed slots.
module fft_bitrev_addr
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_rev
);
  assign addr_rev = ADDR_WIDTH'(bitrev(32'(addr), ADDR_WIDTH));
endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder stage. Captures the final-stage butterfly pair
// write-backs into an N-entry buffer and, after the core's done edge,
// streams the spectrum one bin per cycle in natural bin order.
// Optional build macro FFT_OUT_BITREV_EN: bin k is read from the
// bit-reversed buffer slot instead of slot k.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  input  logic [ADDR_WIDTH-1:0]            wr_addr0,
  input  logic [ADDR_WIDTH-1:0]            wr_addr1,
  input  logic [CPLX_PARTS*DATA_WIDTH-1:0] y0_in,
  input  logic [CPLX_PARTS*DATA_WIDTH-1:0] y1_in,
  input  logic                             fft_done,
  fft_out_reorder_if.master                out_if,
  output logic                             busy,
  output logic                             err_incomplete,
  output logic                             err_drop
);

  localparam int                    CW     = CPLX_PARTS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(N - 1);

  fft_state_t            state_reg;
  logic [CW-1:0]         mem_reg [N];
  logic [N-1:0]          written_reg;
  logic                  done_prev_reg;
  logic [ADDR_WIDTH-1:0] k_reg;
  logic                  out_valid_reg;
  logic [CW-1:0]         out_data_reg;
  logic                  out_last_reg;
  logic                  busy_reg;
  logic                  err_incomplete_reg;
  logic                  err_drop_reg;

  logic                  done_rise;
  logic                  in_collect;
  logic                  wr_en;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] rd_k;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         rd_data;
  logic [N-1:0]          wr_bits;
  logic [N-1:0]          frame_mask;

  assign done_rise  = fft_done & ~done_prev_reg;
  assign in_collect = (state_reg == S_COLLECT);
  // Writes are only accepted while collecting; during a drain they are dropped.
  assign wr_en      = wr_valid & in_collect;
  assign handshake  = out_valid_reg & out_if.out_ready;
  // Next bin to present: bin 0 when a drain starts, otherwise k+1.
  assign rd_k       = (in_collect && done_rise) ? '0 : k_reg + 1'b1;

`ifdef FFT_OUT_BITREV_EN
  fft_bitrev_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bitrev (
    .addr     (rd_k),
    .addr_rev (rd_addr)
  );
`else
  assign rd_addr = rd_k;
`endif

  // Mask bits touched by this cycle's pair write.
  always_comb begin
    wr_bits = '0;
    if (wr_en) begin
      wr_bits[wr_addr0] = 1'b1;
      wr_bits[wr_addr1] = 1'b1;
    end
  end

  assign frame_mask = written_reg | wr_bits;

  // Buffer read with same-cycle write forwarding so a pair written on the
  // done edge is visible to bin 0; y1 takes priority as in the buffer itself.
  always_comb begin
    rd_data = mem_reg[rd_addr];
    if (wr_en && (wr_addr0 == rd_addr)) rd_data = y0_in;
    if (wr_en && (wr_addr1 == rd_addr)) rd_data = y1_in;
  end

  // Sample buffer: pair write, y1 written last so it wins on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[wr_addr0] <= y0_in;
      mem_reg[wr_addr1] <= y1_in;
    end
  end

  // Collect/drain FSM with registered stream outputs and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= S_COLLECT;
      written_reg        <= '0;
      done_prev_reg      <= 1'b0;
      k_reg              <= '0;
      out_valid_reg      <= 1'b0;
      out_data_reg       <= '0;
      out_last_reg       <= 1'b0;
      busy_reg           <= 1'b0;
      err_incomplete_reg <= 1'b0;
      err_drop_reg       <= 1'b0;
    end else begin
      done_prev_reg <= fft_done;
      case (state_reg)
        S_COLLECT: begin
          written_reg <= frame_mask;
          if (done_rise) begin
            state_reg     <= S_DRAIN;
            busy_reg      <= 1'b1;
            out_valid_reg <= 1'b1;
            k_reg         <= '0;
            out_data_reg  <= rd_data;
            out_last_reg  <= 1'b0;
            if (frame_mask != '1) err_incomplete_reg <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (wr_valid || done_rise) err_drop_reg <= 1'b1;
          if (handshake) begin
            if (out_last_reg) begin
              state_reg     <= S_COLLECT;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              written_reg   <= '0;
            end else begin
              k_reg        <= rd_k;
              out_data_reg <= rd_data;
              out_last_reg <= (rd_k == LAST_K);
            end
          end
        end
        default: state_reg <= S_COLLECT;
      endcase
    end
  end

  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_data  = out_data_reg;
  assign out_if.out_index = k_reg;
  assign out_if.out_last  = out_last_reg;
  assign busy             = busy_reg;
  assign err_incomplete   = err_incomplete_reg;
  assign err_drop         = err_drop_reg;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder (N=16, 16-bit components). Expected
// bins come from the write pattern; with FFT_OUT_BITREV_EN defined the
// expected source slot is the 4-bit reversal of k.
module tb_fft_out_reorder;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr0 = '0;
  logic [AW-1:0] wr_addr1 = '0;
  logic [31:0]   y0_in = '0;
  logic [31:0]   y1_in = '0;
  logic          fft_done = 1'b0;
  logic          busy;
  logic          err_incomplete;
  logic          err_drop;

  int n_checks = 0;
  int n_fail   = 0;

  fft_out_reorder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fft_out_reorder #(
    .N          (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_addr0       (wr_addr0),
    .wr_addr1       (wr_addr1),
    .y0_in          (y0_in),
    .y1_in          (y1_in),
    .fft_done       (fft_done),
    .out_if         (bus.master),
    .busy           (busy),
    .err_incomplete (err_incomplete),
    .err_drop       (err_drop)
  );

  always #5 clk = ~clk;

  // Value written to slot a: pair i=a/2 gives y0={i,0}, y1={i,-i}.
  function automatic logic [31:0] pat(input int a);
    int          i;
    logic [15:0] re;
    logic [15:0] im;
    i  = a / 2;
    re = 16'(i);
    im = (a % 2 == 1) ? 16'(-i) : 16'h0000;
    return {re, im};
  endfunction

  // Buffer slot that should supply bin k.
  function automatic int bin_src(input int k);
`ifdef FFT_OUT_BITREV_EN
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pair(input int i, input logic done);
    wr_valid = 1'b1;
    wr_addr0 = AW'(2 * i);
    wr_addr1 = AW'(2 * i + 1);
    y0_in    = pat(2 * i);
    y1_in    = pat(2 * i + 1);
    fft_done = done;
    tick();
    wr_valid = 1'b0;
    fft_done = 1'b0;
  endtask

  // Write pairs 1..npairs-1, then pair 0 together with the done edge.
  task automatic load_frame(input int npairs);
    for (int i = 1; i < npairs; i++) write_pair(i, 1'b0);
    chk("collect_busy", 64'(busy), 64'd0);
    chk("collect_valid", 64'(bus.out_valid), 64'd0);
    write_pair(0, 1'b1);
  endtask

  // Drain with out_ready high; optionally inject a write + done rise at inj_k.
  task automatic drain(input string tag, input int inj_k);
    int hs;
    hs = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_index"}, 64'(bus.out_index), 64'(k));
      chk({tag, "_data"}, 64'(bus.out_data), 64'(pat(bin_src(k))));
      chk({tag, "_last"}, 64'(bus.out_last), 64'(k == N - 1));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (k == inj_k) begin
        wr_valid = 1'b1;
        wr_addr0 = 4'd6;
        wr_addr1 = 4'd7;
        y0_in    = 32'hDEAD_BEEF;
        y1_in    = 32'hCAFE_F00D;
        fft_done = 1'b1;
      end
      tick();
      wr_valid = 1'b0;
      fft_done = 1'b0;
      hs++;
    end
    chk({tag, "_handshakes"}, 64'(hs), 64'(N));
    chk({tag, "_valid_after"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int hs;
    bus.out_ready = 1'b0;

    // Reset values while rst is held.
    #2;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_index", 64'(bus.out_index), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_inc", 64'(err_incomplete), 64'd0);
    chk("rst_err_drop", 64'(err_drop), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("step: reset released");

    // Frame 1: full frame, last pair written on the done edge, ready held high.
    load_frame(8);
    chk("f1_err_inc", 64'(err_incomplete), 64'd0);
    drain("f1", -1);
    chk("f1_err_drop", 64'(err_drop), 64'd0);
    $display("step: frame 1 drained");

    // Frame 2: same data, ready pattern 1,0,0,1 repeating.
    bus.out_ready = 1'b0;
    load_frame(8);
    k  = 0;
    hs = 0;
    for (int c = 0; c < 80 && k < N; c++) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      chk("f2_valid", 64'(bus.out_valid), 64'd1);
      chk("f2_index", 64'(bus.out_index), 64'(k));
      chk("f2_data", 64'(bus.out_data), 64'(pat(bin_src(k))));
      chk("f2_last", 64'(bus.out_last), 64'(k == N - 1));
      tick();
      if (bus.out_ready) begin
        k++;
        hs++;
      end
    end
    chk("f2_handshakes", 64'(hs), 64'(N));
    chk("f2_valid_after", 64'(bus.out_valid), 64'd0);
    chk("f2_errors", 64'({err_incomplete, err_drop}), 64'd0);
    bus.out_ready = 1'b1;
    $display("step: frame 2 drained with stalls");

    // Frame 3: write and done rise injected at k=5 must be ignored.
    load_frame(8);
    drain("f3", 5);
    chk("f3_err_drop", 64'(err_drop), 64'd1);
    chk("f3_err_inc", 64'(err_incomplete), 64'd0);
    $display("step: frame 3 drained with dropped write");

    // Frame 4: only 14 bins written; full drain of the stale buffer still runs.
    load_frame(7);
    chk("f4_err_inc", 64'(err_incomplete), 64'd1);
    drain("f4", -1);
    $display("step: frame 4 incomplete frame drained");

    // Frame 5: reset during the drain at k=7.
    load_frame(8);
    for (int i = 0; i < 7; i++) tick();
    chk("f5_index_k7", 64'(bus.out_index), 64'd7);
    chk("f5_data_k7", 64'(bus.out_data), 64'(pat(bin_src(7))));
    rst = 1'b1;
    #1;
    chk("f5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("f5_rst_data", 64'(bus.out_data), 64'd0);
    chk("f5_rst_index", 64'(bus.out_index), 64'd0);
    chk("f5_rst_busy", 64'(busy), 64'd0);
    chk("f5_rst_errors", 64'({err_incomplete, err_drop}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    $display("step: reset mid-drain");

    // Frame 6: full frame after the abort drains from bin 0.
    load_frame(8);
    drain("f6", -1);
    chk("f6_errors", 64'({err_incomplete, err_drop}), 64'd0);
    $display("step: frame 6 drained after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output stage placed directly after the shared-butterfly FFT core. It captures the butterfly pair write-backs of the final stage, `{re,im}` y0/y1, into an N-entry buffer. After the core's done pulse, it streams the finished spectrum one bin per cycle in natural bin order on a valid/ready interface, so downstream logic never sees butterfly write ordering.

## Interface
- `N`, 16, FFT length (power of two, ≥4)
- `DATA_WIDTH`, 16, width of each real/imag component
- `ADDR_WIDTH`, `$clog2(N)`, bin index width
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `wr_valid` in 1: final-stage pair write strobe
- `wr_addr0` in ADDR_WIDTH: buffer address for `y0_in`
- `wr_addr1` in ADDR_WIDTH: buffer address for `y1_in`
- `y0_in` in 2*DATA_WIDTH: `{re[2DW-1:DW], im[DW-1:0]}`
- `y1_in` in 2*DATA_WIDTH: same packing
- `fft_done` in 1: core frame-complete level/pulse; sampled as rising edge
- `out_valid` out 1: `out_data` holds a bin
- `out_ready` in 1: consumer accepts
- `out_data` out 2*DATA_WIDTH: bin value, same packing
- `out_index` out ADDR_WIDTH: bin number k
- `out_last` out 1: high with bin N-1
- `busy` out 1: high in S_DRAIN
- `err_incomplete` out 1: sticky; frame drained with fewer than N distinct bins written
- `err_drop` out 1: sticky; write or done arrived during S_DRAIN

## Operation
- Storage: N × 2*DATA_WIDTH register array with combinational read, plus N-bit `written` mask.
- **S_COLLECT** (reset state):
  - On `wr_valid`, store `mem[wr_addr0]=y0_in` and `mem[wr_addr1]=y1_in`, and set both mask bits.
  - If `wr_addr0==wr_addr1`, y1 wins.
- **S_COLLECT → S_DRAIN** on the `fft_done` rising edge (registered previous value).
  - A write in the same cycle is stored and included in the frame.
  - If the mask (including that write) is not all-ones, set `err_incomplete`. Drain still proceeds; unwritten entries hold stale/zero data.
  - Load the output register with bin 0.
- **S_DRAIN**:
  - `out_valid=1`.
  - On `out_valid && out_ready`, k increments and the output register loads bin k+1.
  - The handshake on bin N-1 (`out_last=1`) returns to S_COLLECT, clears the mask and drops `out_valid` the next cycle.
  - `out_valid` never deasserts before the handshake; `out_data`/`out_index` are stable while stalled.
  - `wr_valid` or a `fft_done` rise in S_DRAIN is ignored (no memory change) and sets `err_drop`.
- Error flags clear only on `rst`.
- Data is passed unmodified; no scaling or rounding.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`, `busy=0`, `err_incomplete=0`, `err_drop=0`; state S_COLLECT, mask 0, memory 0.
- A write at edge t is readable for a drain starting at edge t.
- `fft_done` rise sampled at edge t: `out_valid=1` with bin 0 after edge t (latency 1).
- Throughput is 1 bin per cycle with `out_ready` held high, so a frame takes N cycles. `busy` is high for exactly N cycles under a constant-high `out_ready`.
- A new frame's writes may start the cycle after the last handshake.
- `rst` mid-drain aborts immediately and asynchronously; outputs go to reset values.

## Configuration
- `FFT_OUT_BITREV_EN`:
  - Defined: bin k is read from `mem[bitrev(k)]`. Use this for cores that write final results in bit-reversed slots.
  - Undefined: bin k is read from `mem[k]`.
- `out_index` is k in both cases. The mask check is unaffected.

## Structure
- Shared package `fft_pkg`:
  - state encodings S_COLLECT/S_DRAIN
  - complex packing widths
  - `bitrev(addr)` function used with ADDR_WIDTH
- One sub-module, `fft_bitrev_addr`: combinational, parameterised ADDR_WIDTH, instantiated only under `FFT_OUT_BITREV_EN`.

## Test plan
- Write pairs (2i, 2i+1) with `y0={i,0}`, `y1={i,-i}` for i=0..7, pulse `fft_done`, hold `out_ready=1` -> 16 consecutive bins k=0..15 matching the writes, `out_last` only at k=15, `busy` high 16 cycles, no errors.
- Same frame with `out_ready` toggling 1,0,0,1… -> data/index stable during stalls, order unchanged, exactly 16 handshakes.
- Macro defined, write `mem[a]=a` for a=0..15 -> output k yields `bitrev4(k)`, e.g. k=1 gives 8 and k=3 gives 12.
- Write only 14 bins then `fft_done` -> `err_incomplete=1`, full 16-bin drain still occurs.
- `wr_valid` and `fft_done` pulse during drain at k=5 -> `err_drop=1`, remaining bins unchanged.
- Assert `rst` at k=7 of drain -> outputs zero immediately; a subsequent full frame drains correctly from bin 0.
